// File: rtl/parity_checker_if.sv
// Serial parity checker bus: bit-stream input side plus deframed result side.
interface parity_checker_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_bit;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err;
  logic [7:0]           err_cnt;

  modport master (
    output in_valid, in_bit,
    input  busy, done, data_out, parity_err, err_cnt
  );

  modport slave (
    input  in_valid, in_bit,
    output busy, done, data_out, parity_err, err_cnt
  );
endinterface

// File: rtl/parity_checker.sv
// Framed serial parity checker: XOR-accumulates DATA_BITS data bits (LSB first),
// then checks the trailing parity bit and reports word, pass/fail and a saturating error count.
module parity_checker #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input logic             clk,
  input logic             rst,
  parity_checker_if.slave bus
);
  localparam int                CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t               state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS-1:0] data_out_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 acc_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 parity_err_reg;
  logic [7:0]           err_cnt_reg;
  logic                 frame_err;

  // cnt_reg is 0 in IDLE, so the same per-bit write decode lands the first bit at index 0.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      assign shift_next[gi] = (state_reg != PARITY && cnt_reg == CNT_W'(gi))
                              ? bus.in_bit : shift_reg[gi];
    end
  endgenerate

  assign frame_err = acc_reg ^ bus.in_bit ^ ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      cnt_reg        <= '0;
      acc_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      parity_err_reg <= 1'b0;
      err_cnt_reg    <= 8'd0;
    end else begin
      done_reg <= 1'b0;
      if (bus.in_valid) begin
        unique case (state_reg)
          IDLE: begin
            shift_reg <= shift_next;
            acc_reg   <= bus.in_bit;
            cnt_reg   <= CNT_W'(1);
            busy_reg  <= 1'b1;
            state_reg <= (DATA_BITS == 1) ? PARITY : DATA;
          end
          DATA: begin
            shift_reg <= shift_next;
            acc_reg   <= acc_reg ^ bus.in_bit;
            cnt_reg   <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_DATA)
              state_reg <= PARITY;
          end
          PARITY: begin
            data_out_reg   <= shift_reg;
            parity_err_reg <= frame_err;
            done_reg       <= 1'b1;
            if (frame_err && err_cnt_reg != 8'hFF)
              err_cnt_reg <= err_cnt_reg + 8'd1;
            acc_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.data_out   = data_out_reg;
  assign bus.parity_err = parity_err_reg;
  assign bus.err_cnt    = err_cnt_reg;
endmodule

// File: tb/tb_parity_checker.sv
// Bench for parity_checker: an 8-bit even-parity instance and a 1-bit odd-parity instance,
// checked every cycle against a frame-level model plus hand-computed literal expectations.
module tb_parity_checker;
  logic clk;
  logic [1:0] rs;
  logic [1:0] v;
  logic [1:0] b;

  parity_checker_if #(.DATA_BITS(8)) if8 ();
  parity_checker_if #(.DATA_BITS(1)) if1 ();

  parity_checker #(.DATA_BITS(8), .ODD(1'b0)) u8 (.clk(clk), .rst(rs[0]), .bus(if8));
  parity_checker #(.DATA_BITS(1), .ODD(1'b1)) u1 (.clk(clk), .rst(rs[1]), .bus(if1));

  assign if8.in_valid = v[0];
  assign if8.in_bit   = b[0];
  assign if1.in_valid = v[1];
  assign if1.in_bit   = b[1];

  logic [1:0]  d_busy, d_done, d_perr;
  logic [31:0] d_data [2];
  int          d_cnt  [2];
  assign d_busy = {if1.busy, if8.busy};
  assign d_done = {if1.done, if8.done};
  assign d_perr = {if1.parity_err, if8.parity_err};
  assign d_data[0] = {24'd0, if8.data_out};
  assign d_data[1] = {31'd0, if1.data_out};
  assign d_cnt[0]  = int'(if8.err_cnt);
  assign d_cnt[1]  = int'(if1.err_cnt);

  localparam int NB   [2] = '{8, 1};
  localparam bit ODDS [2] = '{1'b0, 1'b1};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;
  int done_cnt  [2] = '{0, 0};
  int last_done [2] = '{0, 0};
  int prev_done [2] = '{0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: collect bits, then judge the frame by counting ones.
  function automatic bit frame_err(input logic [31:0] word, input logic p, input bit odd);
    return bit'(((($countones(word) + int'(p)) % 2) != 0) ^ odd);
  endfunction

  int          m_n    [2];
  logic [31:0] m_word [2];
  logic        e_busy [2];
  logic        e_done [2];
  logic [31:0] e_data [2];
  logic        e_perr [2];
  int          e_cnt  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rs[k]) begin
        m_n[k] <= 0; m_word[k] <= 0; e_busy[k] <= 0; e_done[k] <= 0;
        e_data[k] <= 0; e_perr[k] <= 0; e_cnt[k] <= 0;
      end else begin
        e_done[k] <= 0;
        if (v[k]) begin
          if (m_n[k] == NB[k]) begin
            e_data[k] <= m_word[k];
            e_perr[k] <= frame_err(m_word[k], b[k], ODDS[k]);
            e_done[k] <= 1;
            e_busy[k] <= 0;
            m_n[k]    <= 0;
            if (frame_err(m_word[k], b[k], ODDS[k]) && e_cnt[k] < 255)
              e_cnt[k] <= e_cnt[k] + 1;
          end else begin
            m_word[k] <= (m_n[k] == 0 ? 32'd0 : m_word[k]) | (32'(b[k]) << m_n[k]);
            m_n[k]    <= m_n[k] + 1;
            e_busy[k] <= 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k), int'(d_busy[k]), int'(e_busy[k]));
        check($sformatf("done%0d", k), int'(d_done[k]), int'(e_done[k]));
        check($sformatf("data%0d", k), int'(d_data[k]), int'(e_data[k]));
        check($sformatf("perr%0d", k), int'(d_perr[k]), int'(e_perr[k]));
        check($sformatf("errcnt%0d", k), d_cnt[k], e_cnt[k]);
        if (d_done[k] === 1'b1) begin
          prev_done[k] = last_done[k];
          last_done[k] = cyc;
          done_cnt[k]++;
          if (k == 0 || d_cnt[k] < 3 || d_cnt[k] > 252)
            $display("frame dut%0d cycle=%0d data=0x%0h parity_err=%0d err_cnt=%0d",
                     k, cyc, d_data[k], d_perr[k], d_cnt[k]);
        end
      end
    end
  end

  task automatic send_bit(input int k, input logic bv);
    v[k] = 1'b1;
    b[k] = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    v[k] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int k, input int nbits, input logic [31:0] word,
                            input logic p, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      send_bit(k, word[i]);
      if (gaps) idle(k, 1);
    end
    send_bit(k, p);
  endtask

  int dc;

  initial begin
    rs = 2'b11; v = 2'b00; b = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rs = 2'b00;
    chk_en = 1;
    check("reset_busy", int'(if8.busy), 0);
    check("reset_done", int'(if8.done), 0);
    check("reset_data", int'(if8.data_out), 0);
    check("reset_errcnt", int'(if8.err_cnt), 0);

    // 0xA5 with even parity 0: passes
    send_frame(0, 8, 32'hA5, 1'b0, 0);
    check("a5_done", int'(if8.done), 1);
    check("a5_data", int'(if8.data_out), 'hA5);
    check("a5_perr", int'(if8.parity_err), 0);
    check("a5_errcnt", int'(if8.err_cnt), 0);
    idle(0, 1);
    check("a5_done_low", int'(if8.done), 0);

    // 0x07 has three ones: parity 0 fails, parity 1 passes
    send_frame(0, 8, 32'h07, 1'b0, 0);
    check("07p0_perr", int'(if8.parity_err), 1);
    check("07p0_errcnt", int'(if8.err_cnt), 1);
    send_frame(0, 8, 32'h07, 1'b1, 0);
    check("07p1_perr", int'(if8.parity_err), 0);
    check("07p1_errcnt", int'(if8.err_cnt), 1);
    idle(0, 2);

    // 0x3C with a gap after every bit
    dc = done_cnt[0];
    send_frame(0, 8, 32'h3C, 1'b0, 1);
    check("3c_data", int'(if8.data_out), 'h3C);
    check("3c_perr", int'(if8.parity_err), 0);
    idle(0, 3);
    check("3c_one_done", done_cnt[0] - dc, 1);

    // back-to-back frames with no dead cycle
    send_frame(0, 8, 32'hFF, 1'b0, 0);
    check("ff_perr", int'(if8.parity_err), 0);
    send_frame(0, 8, 32'h01, 1'b0, 0);
    check("01_perr", int'(if8.parity_err), 1);
    check("01_data", int'(if8.data_out), 'h01);
    check("01_errcnt", int'(if8.err_cnt), 2);
    idle(0, 1);
    check("b2b_spacing", last_done[0] - prev_done[0], 9);

    // reset mid-frame, with in_valid high on the reset edge
    dc = done_cnt[0];
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    check("mid_busy", int'(if8.busy), 1);
    rs[0] = 1'b1; v[0] = 1'b1; b[0] = 1'b1;
    @(posedge clk);
    #1;
    rs[0] = 1'b0;
    idle(0, 2);
    check("rst_busy", int'(if8.busy), 0);
    check("rst_errcnt", int'(if8.err_cnt), 0);
    check("rst_no_done", done_cnt[0] - dc, 0);
    send_frame(0, 8, 32'h55, 1'b0, 0);
    check("55_data", int'(if8.data_out), 'h55);
    check("55_perr", int'(if8.parity_err), 0);
    check("55_errcnt", int'(if8.err_cnt), 0);
    idle(0, 2);

    // DATA_BITS=1, odd parity: bit 0 + parity 0 always fails; counter saturates
    for (int f = 1; f <= 260; f++) begin
      send_frame(1, 1, 32'd0, 1'b0, 0);
      if (f == 1)   check("sat_f1_errcnt", int'(if1.err_cnt), 1);
      if (f == 254) check("sat_f254_errcnt", int'(if1.err_cnt), 254);
      if (f == 255) check("sat_f255_errcnt", int'(if1.err_cnt), 255);
      if (f == 260) begin
        check("sat_f260_errcnt", int'(if1.err_cnt), 255);
        check("sat_f260_perr", int'(if1.parity_err), 1);
        check("sat_f260_done", int'(if1.done), 1);
      end
    end
    idle(1, 3);
    check("sat_frames", done_cnt[1], 260);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
